ctrl_sequencer: RTL and testbench
=================================

// Module: ctrl_sequencer
// PURPOSE
//  Multi-cycle successor to the combinational instruction decoder: fetch/decode/execute/writeback FSM.
//  Owns the PC, the IR and the Z/C flags, which are now internal registers.
//  Adds a stack handshake with stall, correct JMI conditions (Z/NZ/C/NC), HLT and a fault stop.
//  Sits between the ROM, the GPR file, the ALU and the stack. Widths are parametrised.
// PARAMETERS
//  DATA_W   8  GPR/ALU/stack data width; instruction = {opcode[7:0], arg_a[DATA_W], arg_b[DATA_W]}
//  PC_W     8  PC / ROM address width; must be <= DATA_W (CAL pushes the PC onto the stack)
//  REG_AW   4  GPR address width; register index = arg[REG_AW-1:0]
//  GPRJ_IDX 15 register that supplies the target for JMP/JMI
// PORTS
//  clk            in  1          rising-edge clock
//  rst_n          in  1          async active-low reset
//  rom_addr       out PC_W       ROM address, equal to pc; ROM read is synchronous, 1-cycle latency
//  rom_data       in  8+2*DATA_W instruction word
//  gpr_r_addr_a/b out REG_AW     GPR read addresses; read is combinational
//  gpr_r_data_a/b in  DATA_W     GPR read data
//  gpr_w_enable   out 1          GPR write strobe, one cycle, WB only
//  gpr_w_addr     out REG_AW     GPR write address
//  gpr_w_data     out DATA_W     GPR write data
//  alu_operation  out 3          addition/substraction/increment/decrement codes
//  alu_A/alu_B    out DATA_W     ALU operands
//  alu_C          in  DATA_W     ALU result; combinational
//  alu_z/alu_c    in  1          ALU zero/carry for the current operands
//  flags_z/c      out 1          registered flags
//  stack_req      out 1          held high until stack_ack
//  stack_op       out 1          0=push 1=pop
//  stack_wdata    out DATA_W     push data; stable while stack_req is high
//  stack_ack      in  1          completes the transfer; pop data is valid in the same cycle
//  stack_rdata    in  DATA_W     pop data
//  stack_err      in  1          overflow/underflow, sampled with stack_ack
//  halted         out 1          high in HALT state
//  fault          out 1          sticky; set on stack_err or an undefined opcode
// BEHAVIOUR
//  Reset values: pc=0, IR=0, flags=0, state=FETCH. All outputs are 0 except rom_addr=pc.
//  States and transitions:
//   - FETCH: rom_addr=pc -> DECODE.
//   - DECODE: IR<=rom_data -> EXEC.
//   - EXEC: drive GPR read addresses and ALU inputs; latch result/target into internal registers.
//     A stack op (PSH/POP/CAL/RTN) goes to STACK; otherwise -> WB.
//   - STACK: stack_req=1 with stack_op and stack_wdata held; wait any number of cycles.
//     On stack_ack -> WB, capturing stack_rdata. If stack_err is set with stack_ack -> HALT, fault=1.
//   - WB: single-cycle gpr_w_enable for LD/LDR/ADD/SUB/INC/DEC/CLR/FIL/POP.
//     Flags update only for ADD/SUB/INC/DEC/COM. Then pc update -> FETCH.
//   - HLT opcode or undefined opcode -> HALT; undefined sets fault. HALT is left only by reset.
//  Timing: 4 cycles per instruction with no stack op; 5+N cycles with a stack op, N = ack wait.
//  PC update: jump target for JMR/CAL (arg_a[PC_W-1:0]), JMP, taken JMI and RTN (rdata[PC_W-1:0]).
//   Otherwise pc+1, wrapping modulo 2^PC_W (pc=max -> 0).
//  CAL pushes zero-extended pc+1. JMI: arg_a Z->z, NZ->!z, C->c, NC->!c; any other code -> not taken.
//  COM: subtract, flags only, no GPR write.
//  INC/DEC/ADD/SUB results wrap modulo 2^DATA_W; carry comes from the ALU.
//  Reset mid-instruction: stack_req and gpr_w_enable drop asynchronously; no partial write commits.
// TESTING
//  LDR r1,0x05; LDR r2,0xFB; ADD r1,r2 -> r1=0x00, Z=1, C=1; WB write on cycle 12 after reset.
//  JMI NZ with Z=1 -> pc+1; JMI NC with C=0, r15=0x40 -> pc=0x40.
//  CAL 0x20 at pc=0x07 with stack_ack delayed 3 cycles -> stack_wdata=0x08 held 3 cycles, then pc=0x20.
//  RTN, stack_rdata=0x08 -> pc=0x08. POP with stack_err=1 at ack -> halted=1, fault=1, no GPR write.
//  pc=0xFF executing NOP -> next fetch address 0x00. Undefined opcode 0xEE -> HALT, fault=1.
//  rst_n low in STACK with stack_req=1 -> stack_req=0 immediately; restart fetch at 0x00.

Source files
------------

// File: rtl/ctrl_sequencer_if.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer_if
//   Stack handshake between the instruction sequencer (master) and the
//   hardware stack (slave).
//
//   stack_req   master->slave  request, held high until stack_ack
//   stack_op    master->slave  0 = push, 1 = pop
//   stack_wdata master->slave  push data, stable while stack_req is high
//   stack_ack   slave->master  completes the transfer
//   stack_rdata slave->master  pop data, valid in the stack_ack cycle
//   stack_err   slave->master  overflow/underflow, qualified by stack_ack
// ---------------------------------------------------------------------------
interface ctrl_sequencer_if #(
  parameter int DATA_W = 8
) ();

  logic              stack_req;
  logic              stack_op;
  logic [DATA_W-1:0] stack_wdata;
  logic              stack_ack;
  logic [DATA_W-1:0] stack_rdata;
  logic              stack_err;

  modport master (
    output stack_req,
    output stack_op,
    output stack_wdata,
    input  stack_ack,
    input  stack_rdata,
    input  stack_err
  );

  modport slave (
    input  stack_req,
    input  stack_op,
    input  stack_wdata,
    output stack_ack,
    output stack_rdata,
    output stack_err
  );

endinterface

// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
//   Multi-cycle fetch/decode/execute/writeback sequencer. Owns the PC, the
//   instruction register and the Z/C flags. Talks to a synchronous ROM, a
//   combinational-read GPR file, a combinational ALU and a handshaked stack.
//
//   Instruction word: {opcode[7:0], arg_a[DATA_W-1:0], arg_b[DATA_W-1:0]}
//
//   Opcodes:
//     00 NOP            07 CLR  rA<=0       0E POP  rA<=pop
//     01 LD  rA<=rB     08 FIL  rA<=all 1s  0F CAL  push pc+1, pc<=arg_a
//     02 LDR rA<=arg_b  09 COM  flags(rA-rB)10 RTN  pc<=pop
//     03 ADD rA<=rA+rB  0A JMP  pc<=rJ      11 HLT
//     04 SUB rA<=rA-rB  0B JMR  pc<=arg_a   others: undefined -> HALT+fault
//     05 INC rA<=rA+1   0C JMI  pc<=rJ if cond(arg_a)
//     06 DEC rA<=rA-1   0D PSH  push rA
//   JMI conditions (arg_a): 0=Z 1=NZ 2=C 3=NC, anything else never taken.
//   ALU codes: 0=add 1=subtract 2=increment 3=decrement.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   rom_addr / rom_data         ROM address (=pc) / instruction (1-cycle latency)
//   gpr_r_addr_a/b, gpr_r_data_a/b  GPR read ports (combinational)
//   gpr_w_enable/addr/data      GPR write port, pulsed in WB only
//   alu_operation, alu_A/B      ALU controls and operands
//   alu_C, alu_z, alu_c         ALU result and flags
//   flags_z, flags_c            registered flags
//   stk                         stack handshake (master side)
//   halted, fault               HALT state indicator, sticky fault
// ---------------------------------------------------------------------------
module ctrl_sequencer #(
  parameter int DATA_W   = 8,
  parameter int PC_W     = 8,   // must not exceed DATA_W: CAL pushes the PC
  parameter int REG_AW   = 4,
  parameter int GPRJ_IDX = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,

  output logic [PC_W-1:0]       rom_addr,
  input  logic [8+2*DATA_W-1:0] rom_data,

  output logic [REG_AW-1:0]     gpr_r_addr_a,
  output logic [REG_AW-1:0]     gpr_r_addr_b,
  input  logic [DATA_W-1:0]     gpr_r_data_a,
  input  logic [DATA_W-1:0]     gpr_r_data_b,
  output logic                  gpr_w_enable,
  output logic [REG_AW-1:0]     gpr_w_addr,
  output logic [DATA_W-1:0]     gpr_w_data,

  output logic [2:0]            alu_operation,
  output logic [DATA_W-1:0]     alu_A,
  output logic [DATA_W-1:0]     alu_B,
  input  logic [DATA_W-1:0]     alu_C,
  input  logic                  alu_z,
  input  logic                  alu_c,

  output logic                  flags_z,
  output logic                  flags_c,

  ctrl_sequencer_if.master      stk,

  output logic                  halted,
  output logic                  fault
);

  // Opcodes
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LD  = 8'h01;
  localparam logic [7:0] OP_LDR = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_SUB = 8'h04;
  localparam logic [7:0] OP_INC = 8'h05;
  localparam logic [7:0] OP_DEC = 8'h06;
  localparam logic [7:0] OP_CLR = 8'h07;
  localparam logic [7:0] OP_FIL = 8'h08;
  localparam logic [7:0] OP_COM = 8'h09;
  localparam logic [7:0] OP_JMP = 8'h0A;
  localparam logic [7:0] OP_JMR = 8'h0B;
  localparam logic [7:0] OP_JMI = 8'h0C;
  localparam logic [7:0] OP_PSH = 8'h0D;
  localparam logic [7:0] OP_POP = 8'h0E;
  localparam logic [7:0] OP_CAL = 8'h0F;
  localparam logic [7:0] OP_RTN = 8'h10;
  localparam logic [7:0] OP_HLT = 8'h11;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_INC = 3'd2;
  localparam logic [2:0] ALU_DEC = 3'd3;

  // JMI condition codes carried in arg_a
  localparam logic [DATA_W-1:0] JC_Z  = DATA_W'(0);
  localparam logic [DATA_W-1:0] JC_NZ = DATA_W'(1);
  localparam logic [DATA_W-1:0] JC_C  = DATA_W'(2);
  localparam logic [DATA_W-1:0] JC_NC = DATA_W'(3);

  localparam logic [REG_AW-1:0] JREG = REG_AW'(GPRJ_IDX);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_STACK  = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [8+2*DATA_W-1:0]  ir_q, ir_d;
  logic                   z_q, z_d, c_q, c_d;
  // Values captured in EXEC/STACK and committed in WB
  logic [DATA_W-1:0]      res_q, res_d;
  logic                   fz_q, fz_d, fc_q, fc_d;
  logic [PC_W-1:0]        tgt_q, tgt_d;
  logic                   jump_q, jump_d;
  logic [DATA_W-1:0]      swdata_q, swdata_d;
  logic                   fault_q, fault_d;

  logic [7:0]             opc;
  logic [DATA_W-1:0]      arg_a, arg_b;
  logic [PC_W-1:0]        pc_inc;
  logic                   op_writes, op_flags, op_pops;

  assign opc    = ir_q[8+2*DATA_W-1 -: 8];
  assign arg_a  = ir_q[2*DATA_W-1 -: DATA_W];
  assign arg_b  = ir_q[DATA_W-1:0];
  assign pc_inc = pc_q + PC_W'(1);   // natural wrap at 2^PC_W

  assign op_writes = opc inside {OP_LD, OP_LDR, OP_ADD, OP_SUB, OP_INC,
                                 OP_DEC, OP_CLR, OP_FIL, OP_POP};
  assign op_flags  = opc inside {OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_COM};
  assign op_pops   = opc inside {OP_POP, OP_RTN};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      res_q    <= '0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
      tgt_q    <= '0;
      jump_q   <= 1'b0;
      swdata_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      z_q      <= z_d;
      c_q      <= c_d;
      res_q    <= res_d;
      fz_q     <= fz_d;
      fc_q     <= fc_d;
      tgt_q    <= tgt_d;
      jump_q   <= jump_d;
      swdata_q <= swdata_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    z_d      = z_q;
    c_d      = c_q;
    res_d    = res_q;
    fz_d     = fz_q;
    fc_d     = fc_q;
    tgt_d    = tgt_q;
    jump_d   = jump_q;
    swdata_d = swdata_q;
    fault_d  = fault_q;

    gpr_r_addr_a    = '0;
    gpr_r_addr_b    = '0;
    alu_operation   = ALU_ADD;
    alu_A           = '0;
    alu_B           = '0;
    gpr_w_enable    = 1'b0;
    gpr_w_addr      = '0;
    gpr_w_data      = '0;
    stk.stack_req   = 1'b0;
    stk.stack_op    = 1'b0;
    stk.stack_wdata = '0;

    unique case (state_q)
      S_FETCH: begin
        // rom_addr already equals pc; the ROM answers next cycle
        state_d = S_DECODE;
      end

      S_DECODE: begin
        ir_d    = rom_data;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        // Jumps read the target register on port A instead of rA
        gpr_r_addr_a = (opc inside {OP_JMP, OP_JMI}) ? JREG : arg_a[REG_AW-1:0];
        gpr_r_addr_b = arg_b[REG_AW-1:0];
        alu_A        = gpr_r_data_a;
        alu_B        = gpr_r_data_b;
        jump_d       = 1'b0;
        state_d      = S_WB;
        case (opc)
          OP_NOP: ;
          OP_LD:  res_d = gpr_r_data_b;
          OP_LDR: res_d = arg_b;
          OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_COM: begin
            case (opc)
              OP_ADD:  alu_operation = ALU_ADD;
              OP_INC:  alu_operation = ALU_INC;
              OP_DEC:  alu_operation = ALU_DEC;
              default: alu_operation = ALU_SUB;   // SUB and COM
            endcase
            res_d = alu_C;
            fz_d  = alu_z;
            fc_d  = alu_c;
          end
          OP_CLR: res_d = '0;
          OP_FIL: res_d = '1;
          OP_JMP: begin
            tgt_d  = gpr_r_data_a[PC_W-1:0];
            jump_d = 1'b1;
          end
          OP_JMR: begin
            tgt_d  = arg_a[PC_W-1:0];
            jump_d = 1'b1;
          end
          OP_JMI: begin
            tgt_d = gpr_r_data_a[PC_W-1:0];
            case (arg_a)
              JC_Z:    jump_d = z_q;
              JC_NZ:   jump_d = !z_q;
              JC_C:    jump_d = c_q;
              JC_NC:   jump_d = !c_q;
              default: jump_d = 1'b0;
            endcase
          end
          OP_PSH: begin
            swdata_d = gpr_r_data_a;
            state_d  = S_STACK;
          end
          OP_POP: state_d = S_STACK;
          OP_CAL: begin
            swdata_d = DATA_W'(pc_inc);   // return address, zero-extended
            tgt_d    = arg_a[PC_W-1:0];
            jump_d   = 1'b1;
            state_d  = S_STACK;
          end
          OP_RTN: begin
            jump_d  = 1'b1;               // target arrives with stack_ack
            state_d = S_STACK;
          end
          OP_HLT: state_d = S_HALT;
          default: begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end
        endcase
      end

      S_STACK: begin
        stk.stack_req   = 1'b1;
        stk.stack_op    = op_pops;
        stk.stack_wdata = swdata_q;
        if (stk.stack_ack) begin
          if (stk.stack_err) begin
            // Abandon the instruction: no writeback, no PC change
            state_d = S_HALT;
            fault_d = 1'b1;
          end else begin
            res_d = stk.stack_rdata;
            if (opc == OP_RTN) begin
              tgt_d = stk.stack_rdata[PC_W-1:0];
            end
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        gpr_w_enable = op_writes;
        gpr_w_addr   = arg_a[REG_AW-1:0];
        gpr_w_data   = res_q;
        if (op_flags) begin
          z_d = fz_q;
          c_d = fc_q;
        end
        pc_d    = jump_q ? tgt_q : pc_inc;
        state_d = S_FETCH;
      end

      S_HALT: state_d = S_HALT;   // only reset leaves HALT

      default: state_d = S_FETCH;
    endcase
  end

  assign rom_addr = pc_q;
  assign flags_z  = z_q;
  assign flags_c  = c_q;
  assign halted   = (state_q == S_HALT);
  assign fault    = fault_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
module tb_ctrl_sequencer;

  localparam logic [7:0] OP_NOP = 8'h00, OP_LD  = 8'h01, OP_LDR = 8'h02,
                         OP_ADD = 8'h03, OP_INC = 8'h05, OP_DEC = 8'h06,
                         OP_CLR = 8'h07, OP_FIL = 8'h08, OP_COM = 8'h09,
                         OP_JMR = 8'h0B, OP_JMI = 8'h0C, OP_PSH = 8'h0D,
                         OP_POP = 8'h0E, OP_CAL = 8'h0F, OP_RTN = 8'h10,
                         OP_HLT = 8'h11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data;
  logic [3:0]  gpr_r_addr_a, gpr_r_addr_b, gpr_w_addr;
  logic [7:0]  gpr_r_data_a, gpr_r_data_b, gpr_w_data;
  logic        gpr_w_enable;
  logic [2:0]  alu_operation;
  logic [7:0]  alu_A, alu_B, alu_C;
  logic        alu_z, alu_c;
  logic        flags_z, flags_c, halted, fault;

  ctrl_sequencer_if #(.DATA_W(8)) stk ();

  ctrl_sequencer #(.DATA_W(8), .PC_W(8), .REG_AW(4), .GPRJ_IDX(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .gpr_r_addr_a(gpr_r_addr_a), .gpr_r_addr_b(gpr_r_addr_b),
    .gpr_r_data_a(gpr_r_data_a), .gpr_r_data_b(gpr_r_data_b),
    .gpr_w_enable(gpr_w_enable), .gpr_w_addr(gpr_w_addr), .gpr_w_data(gpr_w_data),
    .alu_operation(alu_operation), .alu_A(alu_A), .alu_B(alu_B),
    .alu_C(alu_C), .alu_z(alu_z), .alu_c(alu_c),
    .flags_z(flags_z), .flags_c(flags_c),
    .stk(stk),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Environment: synchronous ROM, GPR file, ALU
  logic [23:0] rom [256];
  logic [7:0]  regs [16];
  logic [7:0]  init_regs [16];
  logic [8:0]  alu_sum;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk) begin
    if (!rst_n) regs <= init_regs;
    else if (gpr_w_enable) regs[gpr_w_addr] <= gpr_w_data;
  end
  assign gpr_r_data_a = regs[gpr_r_addr_a];
  assign gpr_r_data_b = regs[gpr_r_addr_b];

  always_comb begin
    alu_sum = 9'd0;
    case (alu_operation)
      3'd0: alu_sum = {1'b0, alu_A} + {1'b0, alu_B};
      3'd1: alu_sum = {1'b0, alu_A} - {1'b0, alu_B};
      3'd2: alu_sum = {1'b0, alu_A} + 9'd1;
      3'd3: alu_sum = {1'b0, alu_A} - 9'd1;
      default: alu_sum = 9'd0;
    endcase
  end
  assign alu_C = alu_sum[7:0];
  assign alu_c = alu_sum[8];
  assign alu_z = (alu_sum[7:0] == 8'd0);

  int n_assert = 0;
  int n_fail   = 0;
  logic [11:0] sb_q [$];   // expected GPR writes {addr, data}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every GPR write must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && gpr_w_enable === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_assert++;
        assert (sb_q.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_unexpected_write observed addr=0x%0h data=0x%0h expected=no write",
                 gpr_w_addr, gpr_w_data);
        end
      end else begin
        chk("sb_gpr_write", {20'd0, gpr_w_addr, gpr_w_data}, {20'd0, sb_q.pop_front()});
      end
    end
  end

  function automatic logic [23:0] ins(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    return {op, a, b};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Enter reset, check reset values, clear the program and stack inputs
  task automatic hold_reset();
    rst_n = 1'b0;
    stk.stack_ack = 1'b0; stk.stack_err = 1'b0; stk.stack_rdata = 8'd0;
    for (int i = 0; i < 256; i++) rom[i] = 24'd0;
    for (int i = 0; i < 16; i++) init_regs[i] = 8'd0;
    tick(2);
    chk("rst_scoreboard_drained", sb_q.size(), 0);
    chk("rst_outputs", {rom_addr, halted, fault, flags_z, flags_c, stk.stack_req, gpr_w_enable}, 14'd0);
  endtask

  task automatic release_reset();
    tick(1);                 // let init_regs load into the GPR model
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (stk.stack_req !== 1'b1 && k < 80) begin
      tick(1);
      k++;
    end
    chk(tag, stk.stack_req, 1);
  endtask

  initial begin
    stk.stack_ack = 1'b0; stk.stack_err = 1'b0; stk.stack_rdata = 8'd0;

    // ---- Arithmetic, flags, conditional jumps
    hold_reset();
    rom[0] = ins(OP_LDR, 8'd1, 8'h05);
    rom[1] = ins(OP_LDR, 8'd2, 8'hFB);
    rom[2] = ins(OP_ADD, 8'd1, 8'd2);
    rom[3] = ins(OP_JMI, 8'd1, 8'd0);    // NZ, Z=1: not taken
    rom[4] = ins(OP_COM, 8'd2, 8'd1);    // 0xFB-0x00: Z=0 C=0
    rom[5] = ins(OP_JMI, 8'd3, 8'd0);    // NC, C=0: taken to r15
    rom[8'h40] = ins(OP_HLT, 8'd0, 8'd0);
    init_regs[15] = 8'h40;
    sb_q.push_back({4'd1, 8'h05});
    sb_q.push_back({4'd2, 8'hFB});
    sb_q.push_back({4'd1, 8'h00});
    release_reset();
    tick(10);
    chk("add_wb_not_before_cycle12", gpr_w_enable, 0);
    tick(1);
    chk("add_wb_cycle12", {gpr_w_enable, gpr_w_addr, gpr_w_data}, {1'b1, 4'd1, 8'h00});
    tick(1);
    chk("add_flags_zc", {flags_z, flags_c}, 2'b11);
    chk("add_next_pc", rom_addr, 8'h03);
    tick(4);
    chk("jmi_nz_not_taken_pc", rom_addr, 8'h04);
    tick(4);
    chk("com_flags", {flags_z, flags_c}, 2'b00);
    tick(4);
    chk("jmi_nc_taken_pc", rom_addr, 8'h40);
    tick(4);
    chk("hlt_halted_fault", {halted, fault}, 2'b10);
    tick(3);
    chk("hlt_stays", {halted, rom_addr}, {1'b1, 8'h40});

    // ---- INC/DEC wrap, LD/CLR/FIL, PC wrap at 0xFF
    hold_reset();
    rom[0] = ins(OP_INC, 8'd6, 8'd0);
    rom[1] = ins(OP_DEC, 8'd7, 8'd0);
    rom[2] = ins(OP_LD,  8'd8, 8'd7);
    rom[3] = ins(OP_CLR, 8'd9, 8'd0);
    rom[4] = ins(OP_FIL, 8'd10, 8'd0);
    rom[5] = ins(OP_JMR, 8'hFF, 8'd0);
    init_regs[6] = 8'hFF;
    init_regs[7] = 8'h00;
    init_regs[9] = 8'h33;
    sb_q.push_back({4'd6, 8'h00});
    sb_q.push_back({4'd7, 8'hFF});
    sb_q.push_back({4'd8, 8'hFF});
    sb_q.push_back({4'd9, 8'h00});
    sb_q.push_back({4'd10, 8'hFF});
    release_reset();
    tick(4);
    chk("inc_wrap_flags", {flags_z, flags_c}, 2'b11);
    tick(4);
    chk("dec_wrap_flags", {flags_z, flags_c}, 2'b01);
    tick(12);
    chk("ld_clr_fil_keep_flags", {flags_z, flags_c}, 2'b01);
    tick(4);
    chk("jmr_pc", rom_addr, 8'hFF);
    tick(4);
    chk("pc_wrap_ff_to_00", rom_addr, 8'h00);

    // ---- CAL / RTN / PSH / POP / stack error
    hold_reset();
    rom[7]     = ins(OP_CAL, 8'h20, 8'd0);
    rom[8'h20] = ins(OP_RTN, 8'd0, 8'd0);
    rom[8]     = ins(OP_PSH, 8'd4, 8'd0);
    rom[9]     = ins(OP_POP, 8'd3, 8'd0);
    rom[10]    = ins(OP_POP, 8'd5, 8'd0);
    init_regs[4] = 8'h5A;
    release_reset();
    wait_req("cal_req");
    chk("cal_op_push", stk.stack_op, 0);
    for (int i = 0; i < 3; i++) begin
      chk("cal_wdata_held", {stk.stack_req, stk.stack_wdata}, {1'b1, 8'h08});
      tick(1);
    end
    stk.stack_ack = 1'b1;
    tick(1);
    stk.stack_ack = 1'b0;
    tick(1);
    chk("cal_pc", rom_addr, 8'h20);
    wait_req("rtn_req");
    chk("rtn_op_pop", stk.stack_op, 1);
    stk.stack_rdata = 8'h08; stk.stack_ack = 1'b1;
    tick(1);
    stk.stack_ack = 1'b0;
    tick(1);
    chk("rtn_pc", rom_addr, 8'h08);
    wait_req("psh_req");
    chk("psh_op_wdata", {stk.stack_op, stk.stack_wdata}, {1'b0, 8'h5A});
    stk.stack_ack = 1'b1;
    tick(1);
    stk.stack_ack = 1'b0;
    tick(1);
    chk("psh_pc", rom_addr, 8'h09);
    wait_req("pop_req");
    sb_q.push_back({4'd3, 8'h77});
    stk.stack_rdata = 8'h77; stk.stack_ack = 1'b1;
    tick(1);
    stk.stack_ack = 1'b0;
    tick(1);
    chk("pop_pc", rom_addr, 8'h0A);
    wait_req("pop_err_req");
    stk.stack_rdata = 8'h99; stk.stack_err = 1'b1; stk.stack_ack = 1'b1;
    tick(1);
    stk.stack_ack = 1'b0; stk.stack_err = 1'b0;
    chk("pop_err_halt", {halted, fault, stk.stack_req}, 3'b110);
    tick(4);
    chk("pop_err_stays", {halted, fault, rom_addr}, {2'b11, 8'h0A});

    // ---- Undefined opcode
    hold_reset();
    chk("fault_cleared_by_reset", fault, 0);
    rom[0] = ins(8'hEE, 8'd0, 8'd0);
    release_reset();
    tick(2);
    chk("undef_not_yet_halted", halted, 0);
    tick(2);
    chk("undef_halt_fault", {halted, fault, rom_addr}, {2'b11, 8'h00});

    // ---- Reset while the stack request is pending
    hold_reset();
    rom[0] = ins(OP_PSH, 8'd4, 8'd0);
    init_regs[4] = 8'hC3;
    release_reset();
    wait_req("rst_mid_req");
    rst_n = 1'b0;
    #1;
    chk("rst_async_req_drop", {stk.stack_req, gpr_w_enable, rom_addr}, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    chk("refetch_req", {stk.stack_req, stk.stack_wdata}, {1'b1, 8'hC3});
    stk.stack_ack = 1'b1;
    tick(1);
    stk.stack_ack = 1'b0;
    tick(1);
    chk("refetch_pc", rom_addr, 8'h01);

    chk("final_scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
